// File: rtl/instr_fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode: {PC, instr} circular buffer with flush.
// Optional zero-latency pass-through for an empty queue: define IFQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int                 DEPTH     = 4,
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  input  logic [PC_W-1:0]            enq_pc_i,
  input  logic [INSTR_W-1:0]         enq_instr_i,
  output logic                       enq_ready_o,
  output logic                       deq_valid_o,
  output logic [PC_W-1:0]            deq_pc_o,
  output logic [INSTR_W-1:0]         deq_instr_o,
  input  logic                       deq_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            bypass, enq_fire, deq_fire, do_wr, do_rd;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign enq_ready_o = !full_o;
  assign count_o     = count_q;
  assign head        = mem_q[rd_ptr_q];

`ifdef IFQ_BYPASS_EN
  assign bypass = empty_o && enq_valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid_o = !empty_o || bypass;

  always_comb begin
    deq_pc_o    = '0;
    deq_instr_o = NOP_INSTR;
    if (bypass) begin
      deq_pc_o    = enq_pc_i;
      deq_instr_o = enq_instr_i;
    end else if (!empty_o) begin
      deq_pc_o    = head.pc;
      deq_instr_o = head.instr;
    end
  end

  assign enq_fire = enq_valid_i && enq_ready_o;
  assign deq_fire = deq_valid_o && deq_ready_i;
  // A bypassed entry taken the same cycle never touches storage.
  assign do_wr    = enq_fire && !flush_i && !(bypass && deq_ready_i);
  assign do_rd    = deq_fire && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= '{pc: enq_pc_i, instr: enq_instr_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (count_q <= CW'(DEPTH));
      assert (!(do_rd && count_q == '0));
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_instr_fetch_queue;
  localparam int          DEPTH   = 4;
  localparam int          PC_W    = 64;
  localparam int          INSTR_W = 32;
  localparam logic [31:0] NOP     = 32'h00000013;

  logic                 clk = 1'b0;
  logic                 reset, flush, enq_v, enq_rdy, deq_v, deq_rdy, empty, full;
  logic [PC_W-1:0]      enq_pc, deq_pc;
  logic [INSTR_W-1:0]   enq_instr, deq_instr;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .enq_valid_i(enq_v), .enq_pc_i(enq_pc), .enq_instr_i(enq_instr), .enq_ready_o(enq_rdy),
    .deq_valid_o(deq_v), .deq_pc_o(deq_pc), .deq_instr_o(deq_instr), .deq_ready_i(deq_rdy),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_enq_fire = 0;
  logic [PC_W-1:0] pc_ctr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a falling edge; compare, then advance the model at the rising edge.
  task automatic tick(input bit do_chk);
    bit               byp, e_rdy, dv, ef, df;
    int               n;
    logic [PC_W-1:0]  epc;
    logic [INSTR_W-1:0] ein;
    #1;
    n   = q.size();
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = (n == 0) && enq_v && !flush;
`endif
    e_rdy = (n != DEPTH);
    dv    = (n != 0) || byp;
    epc   = byp ? enq_pc    : (n != 0 ? q[0].pc    : '0);
    ein   = byp ? enq_instr : (n != 0 ? q[0].instr : NOP);
    if (do_chk) begin
      chk("count",     64'(count),   64'(n));
      chk("empty",     64'(empty),   64'(n == 0));
      chk("full",      64'(full),    64'(n == DEPTH));
      chk("enq_ready", 64'(enq_rdy), 64'(e_rdy));
      chk("deq_valid", 64'(deq_v),   64'(dv));
      chk("deq_pc",    deq_pc,       epc);
      chk("deq_instr", 64'(deq_instr), 64'(ein));
    end
    ef = enq_v && e_rdy;
    df = dv && deq_rdy;
    @(posedge clk);
    last_enq_fire = ef && !flush && !reset;
    if (reset || flush) q.delete();
    else begin
      if (df && !byp) void'(q.pop_front());
      if (ef && !(df && byp)) q.push_back('{pc: enq_pc, instr: enq_instr});
    end
    @(negedge clk);
  endtask

  task automatic offer(input logic [PC_W-1:0] pc);
    enq_v     = 1'b1;
    enq_pc    = pc;
    enq_instr = $urandom;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; enq_v = 1'b0; enq_pc = '0; enq_instr = '0; deq_rdy = 1'b0;
    @(negedge clk);
    tick(0); tick(0);
    reset = 1'b0;
    tick(1);
    chk("reset_nop", 64'(deq_instr), 64'(NOP));

    // Fill to full, hold a 5th offer, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin offer(64'(4 * i)); tick(1); end
    offer(64'h10);
    tick(1); tick(1);
    deq_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (last_enq_fire) break;
    end
    chk("held_offer_taken", 64'(last_enq_fire), 64'd1);
    enq_v = 1'b0;
    repeat (6) tick(1);

    // Back-to-back streaming across pointer wrap.
    flush = 1'b1; tick(1); flush = 1'b0;
    for (int i = 0; i < 10; i++) begin offer(64'(4 * i)); tick(1); end
    enq_v = 1'b0;
    repeat (3) tick(1);

    // Flush with a simultaneous enqueue: the wrong-path PC 0x40 must vanish.
    deq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin offer(64'h20 + 64'(4 * i)); tick(1); end
    flush = 1'b1; offer(64'h40); tick(1);
    flush = 1'b0; enq_v = 1'b0; deq_rdy = 1'b1;
    chk("flush_count", 64'(count), 64'd0);
    repeat (3) tick(1);

    // Full queue dequeued while an offer is pending.
    deq_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin offer(64'h200 + 64'(4 * i)); tick(1); end
    offer(64'h100); deq_rdy = 1'b1;
    tick(1);
    chk("full_deq_rejects", 64'(last_enq_fire), 64'd0);
    tick(1);
    chk("pending_accepted", 64'(last_enq_fire), 64'd1);
    enq_v = 1'b0;
    repeat (6) tick(1);

    // Empty queue offer with ready consumer.
    enq_v = 1'b1; enq_pc = 64'h80; enq_instr = 32'h00500093; deq_rdy = 1'b1;
    tick(1);
    enq_v = 1'b0;
    tick(1); tick(1);

    // Random traffic; an unaccepted offer is held stable.
    pc_ctr = 64'h1000;
    for (int i = 0; i < 500; i++) begin
      if (!(enq_v && !last_enq_fire)) begin
        enq_v = ($urandom_range(0, 3) != 0);
        if (enq_v) begin offer(pc_ctr); pc_ctr += 64'd4; end
      end
      deq_rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      tick(1);
    end
    flush = 1'b0; enq_v = 1'b0;

    // Reset mid-traffic returns to the idle state.
    deq_rdy = 1'b0; offer(64'h3000); tick(1); enq_v = 1'b0;
    reset = 1'b1; tick(0); reset = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Prefetch buffer placed between FetchStage and FD_pipeline. Holds fetched {PC, instruction} pairs so fetch can keep running while decode is stalled.
- Absorbs back-pressure from FD_pipeline ready_i.
- branchTaken from the Memory stage drives flush_i, which discards all wrong-path entries in one cycle.
- Circular-buffer FIFO, valid/ready on both sides, occupancy reported for the fetch-throttle logic.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- PC_W, 64, PC width
- INSTR_W, 32, instruction width
- NOP_INSTR, 32'h00000013, value driven on deq_instr_o when the queue is empty (addi x0,x0,0)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries (branch redirect)
- enq_valid_i  in  1  FetchStage offers an entry
- enq_pc_i  in  PC_W  PC of the offered instruction
- enq_instr_i  in  INSTR_W  offered instruction word
- enq_ready_o  out  1  queue can accept an entry this cycle
- deq_valid_o  out  1  head entry is valid
- deq_pc_o  out  PC_W  head PC
- deq_instr_o  out  INSTR_W  head instruction
- deq_ready_i  in  1  FD_pipeline accepts the head entry
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == DEPTH

Behaviour:
- Single clock domain, clk_i. Reset is synchronous, active-high, on reset_i.
- Reset values:
  - wr_ptr, rd_ptr and count are 0.
  - Outputs: enq_ready_o=1, deq_valid_o=0, deq_pc_o=0, deq_instr_o=NOP_INSTR, count_o=0, empty_o=1, full_o=0.
  - Storage contents are don't-care.
- Handshake:
  - Enqueue fires when enq_valid_i && enq_ready_o.
  - Dequeue fires when deq_valid_o && deq_ready_i.
  - enq_ready_o = !full_o. It does not depend on deq_ready_i (no combinational ready path). A full queue that is dequeued this cycle still rejects enqueue.
  - deq_valid_o = !empty_o.
  - An offered entry must stay stable until accepted. The queue does not check this.
- Data path:
  - On enqueue: mem[wr_ptr] <= {enq_pc_i, enq_instr_i}; wr_ptr increments mod DEPTH.
  - On dequeue: rd_ptr increments mod DEPTH.
  - deq_pc_o / deq_instr_o show mem[rd_ptr] combinationally when deq_valid_o=1. Otherwise they show 0 / NOP_INSTR.
- Latency: an entry enqueued in cycle N is visible on deq_* in cycle N+1 (unless IFQ_BYPASS_EN is defined).
- Count: increments on enqueue-only, decrements on dequeue-only, unchanged on simultaneous enqueue+dequeue or no activity.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are derived from count, not from pointer compare.
- Flush: in the cycle after flush_i=1, wr_ptr=rd_ptr=0 and count=0, regardless of any enqueue or dequeue in the flush cycle.
  - Enqueue in the flush cycle is dropped (wrong-path fetch).
  - Dequeue handshake in the flush cycle still completes from FD_pipeline's view. FD_pipeline flushes on the same signal, so the result is discarded there.
- Priority: reset_i > flush_i > enqueue/dequeue.
- Illegal conditions: dequeue when empty and enqueue when full are impossible given the handshake rules. Assertions check that count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when the queue is empty, enq_valid_i=1 and flush_i=0, the input passes combinationally to deq_*: deq_valid_o=1, deq_pc_o=enq_pc_i, deq_instr_o=enq_instr_i.
  - If deq_ready_i=1 that cycle, the entry is consumed without being written and count stays 0.
  - If deq_ready_i=0, the entry is written normally and count becomes 1.
  - Result is zero-cycle latency through an empty queue.
- Undefined: no bypass path; minimum latency is 1 cycle; deq_* depend only on registered state.

Test Plan:
- Reset then idle: assert reset_i 2 cycles, release -> count_o=0, deq_valid_o=0, deq_instr_o=32'h00000013, enq_ready_o=1.
- Fill and drain (DEPTH=4, deq_ready_i=0): enqueue PCs 0x0,0x4,0x8,0xC -> full_o=1, enq_ready_o=0, a 5th offer of PC 0x10 is held. Then deq_ready_i=1 -> deq_pc_o goes 0x0,0x4,0x8,0xC in order, then 0x10 after it is accepted.
- Steady streaming with wrap: 10 back-to-back enqueues, deq_ready_i=1 every cycle -> count_o stays at 1 (0 with IFQ_BYPASS_EN). Output PCs 0x0..0x24 in order, no loss or duplication across pointer wrap.
- Flush with simultaneous enqueue: queue holds 3 entries, flush_i=1 with enq_valid_i=1 PC 0x40 -> next cycle count_o=0, deq_valid_o=0, and PC 0x40 never appears.
- Full with simultaneous dequeue: count=4, deq_ready_i=1, enq_valid_i=1 -> enq_ready_o=0, next cycle count_o=3, enqueued entry still pending and accepted the following cycle.
- Bypass (IFQ_BYPASS_EN): empty queue, enq PC 0x80 instr 0x00500093, deq_ready_i=1 -> same cycle deq_valid_o=1, deq_pc_o=0x80, next cycle count_o=0.
